// File: rtl/lx32_mem_pkg.sv
// lx32_mem_pkg: shared types and defaults for the LX32 memory-port arbiter.
package lx32_mem_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_e;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/lx32_mem_arbiter.sv
// lx32_mem_arbiter: shares one memory port between fetch (IF) and load/store (D),
// one transaction outstanding, D priority with a starvation bound for IF.
module lx32_mem_arbiter
    import lx32_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic                d_req_we,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_be,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_we,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_be,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                busy,
    output owner_e              owner,
    output logic                proto_err
);

    localparam int         BE_W  = DATA_W / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    logic                proto_err_q, proto_err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                idle, if_win, d_win, rsp_hit;

    always_comb begin
        idle         = state_q == IDLE;
        if_win       = idle && if_req_valid && (!d_req_valid || starve_cnt_q == LIMIT);
        d_win        = idle && d_req_valid && !if_win;
        rsp_hit      = state_q == RSP && mem_rsp_valid;
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        // Any response outside RSP is a protocol violation and is otherwise dropped
        proto_err_d  = proto_err_q || (mem_rsp_valid && state_q != RSP);
        case (state_q)
            IDLE: begin
                if (if_win) begin
                    state_d      = REQ;
                    owner_d      = OWN_IF;
                    addr_d       = if_req_addr;
                    we_d         = 1'b0;
                    wdata_d      = '0;
                    be_d         = '1;
                    starve_cnt_d = '0;
                end else if (d_win) begin
                    state_d      = REQ;
                    owner_d      = OWN_D;
                    addr_d       = d_req_addr;
                    we_d         = d_req_we;
                    wdata_d      = d_req_wdata;
                    be_d         = d_req_be;
                    starve_cnt_d = (if_req_valid && starve_cnt_q != LIMIT) ? starve_cnt_q + 4'd1 : starve_cnt_q;
                end
            end
            REQ:     state_d = mem_req_ready ? RSP : REQ;
            RSP:     state_d = mem_rsp_valid ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            starve_cnt_q <= '0;
            proto_err_q  <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            proto_err_q  <= proto_err_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
        end
    end

    assign if_req_ready  = if_win;
    assign d_req_ready   = d_win;
    assign mem_req_valid = state_q == REQ;
    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_be    = be_q;
    assign if_rsp_valid  = rsp_hit && owner_q == OWN_IF;
    assign d_rsp_valid   = rsp_hit && owner_q == OWN_D;
    assign if_rsp_data   = if_rsp_valid ? mem_rsp_data : '0;
    assign d_rsp_data    = d_rsp_valid ? mem_rsp_data : '0;
    assign busy          = !idle;
    assign owner         = owner_q;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_lx32_mem_arbiter.sv
// tb_lx32_mem_arbiter: scoreboard bench for the LX32 memory-port arbiter.
`timescale 1ns/1ps
`define CHK(n, a, b) check(n, 128'(a), 128'(b))
module tb_lx32_mem_arbiter;
    import lx32_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid = 1'b0, if_req_ready;
    logic [31:0] if_req_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid = 1'b0, d_req_ready, d_req_we = 1'b0;
    logic [31:0] d_req_addr = '0, d_req_wdata = '0;
    logic [3:0]  d_req_be = '0;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        busy, proto_err;
    owner_e      owner;

    always #5 clk = ~clk;

    lx32_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .busy(busy), .owner(owner), .proto_err(proto_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mreq_t;

    typedef struct packed {
        logic        d;
        logic [31:0] data;
    } rsp_t;

    mreq_t exp_mreq[$];
    rsp_t  exp_rsp[$];
    logic  exp_grant[$];

    int checks = 0;
    int fails = 0;
    int mem_delay = 0;
    logic hold_rsp = 1'b0;
    logic stray_req = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        fails++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a == 32'h2000 ? 32'hDEADBEEF : a ^ 32'h5A5A_0000;
    endfunction

    task automatic push_d(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be, input logic want_rsp);
        mreq_t m;
        rsp_t r;
        m.addr = a; m.we = we; m.wdata = wd; m.be = be;
        r.d = 1'b1; r.data = mem_val(a);
        exp_grant.push_back(1'b1);
        exp_mreq.push_back(m);
        if (want_rsp) exp_rsp.push_back(r);
    endtask

    task automatic push_if(input logic [31:0] a);
        mreq_t m;
        rsp_t r;
        m.addr = a; m.we = 1'b0; m.wdata = '0; m.be = 4'hF;
        r.d = 1'b0; r.data = mem_val(a);
        exp_grant.push_back(1'b0);
        exp_mreq.push_back(m);
        exp_rsp.push_back(r);
    endtask

    task automatic wait_ready(input logic is_d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_d ? d_req_ready : if_req_ready) && n < 40);
        if (!(is_d ? d_req_ready : if_req_ready)) flag(is_d ? "d_grant_timeout" : "if_grant_timeout");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 60);
        if (busy) flag("idle_timeout");
    endtask

    task automatic d_op(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be, input logic want_rsp);
        push_d(a, we, wd, be, want_rsp);
        @(posedge clk); #1;
        d_req_valid = 1'b1; d_req_addr = a; d_req_we = we; d_req_wdata = wd; d_req_be = be;
        wait_ready(1'b1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
    endtask

    task automatic if_op(input logic [31:0] a);
        push_if(a);
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = a;
        wait_ready(1'b0);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
    endtask

    // Memory model: ready after mem_delay stall cycles, response the cycle after handshake
    initial begin
        int wcnt;
        logic hs, st;
        logic [31:0] a;
        wcnt = 0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        forever begin
            @(negedge clk);
            hs = mem_req_valid && mem_req_ready;
            a = mem_req_addr;
            st = stray_req;
            if (hs) wcnt = 0;
            else if (mem_req_valid) wcnt++;
            @(posedge clk); #1;
            mem_rsp_valid = (hs && !hold_rsp) || st;
            mem_rsp_data = !mem_rsp_valid ? 32'h0 : (hs && !hold_rsp) ? mem_val(a) : 32'hBAD0_BAD0;
            mem_req_ready = wcnt >= mem_delay;
        end
    end

    // Monitor: grants, memory requests and responses checked against the queues
    initial begin
        mreq_t cur, prev, e;
        rsp_t r;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (if_req_ready || d_req_ready) begin
                    `CHK("grant_exclusive", if_req_ready && d_req_ready, 1'b0);
                    if (exp_grant.size() == 0) flag("grant_unexpected");
                    else `CHK("grant_owner_is_d", d_req_ready, exp_grant.pop_front());
                end
                if (busy) `CHK("ready_while_busy", {if_req_ready, d_req_ready}, 2'b00);
                if (mem_req_valid) begin
                    cur = {mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be};
                    if (prev_v) `CHK("mem_req_stable", cur, prev);
                    prev = cur;
                    prev_v = !mem_req_ready;
                    if (mem_req_ready) begin
                        if (exp_mreq.size() == 0) flag("mem_req_unexpected");
                        else begin
                            e = exp_mreq.pop_front();
                            `CHK("mem_req_fields", cur, e);
                        end
                    end
                end else begin
                    prev_v = 1'b0;
                end
                if (if_rsp_valid || d_rsp_valid) begin
                    `CHK("rsp_exclusive", if_rsp_valid && d_rsp_valid, 1'b0);
                    if (exp_rsp.size() == 0) flag("rsp_unexpected");
                    else begin
                        r = exp_rsp.pop_front();
                        `CHK("rsp_port_is_d", d_rsp_valid, r.d);
                        `CHK("rsp_data", r.d ? d_rsp_data : if_rsp_data, r.data);
                    end
                end
                if (!if_rsp_valid) `CHK("if_rsp_data_zero", if_rsp_data, 32'h0);
                if (!d_rsp_valid) `CHK("d_rsp_data_zero", d_rsp_data, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, n;
        // Reset state
        repeat (3) @(negedge clk);
        `CHK("rst_busy", busy, 1'b0);
        `CHK("rst_mem_req_valid", mem_req_valid, 1'b0);
        `CHK("rst_mem_req_addr", mem_req_addr, 32'h0);
        `CHK("rst_owner", owner, OWN_IF);
        `CHK("rst_proto_err", proto_err, 1'b0);
        `CHK("rst_rsp_valid", {if_rsp_valid, d_rsp_valid}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single load with minimum latency
        mem_delay = 0;
        push_d(32'h2000, 1'b0, 32'h0, 4'hF, 1'b1);
        @(posedge clk); #1;
        d_req_valid = 1'b1; d_req_addr = 32'h2000; d_req_we = 1'b0; d_req_wdata = '0; d_req_be = 4'hF;
        wait_ready(1'b1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        @(negedge clk);
        `CHK("load_t1_mem_valid", mem_req_valid, 1'b1);
        `CHK("load_t1_owner", owner, OWN_D);
        `CHK("load_t1_no_rsp", d_rsp_valid, 1'b0);
        @(negedge clk);
        `CHK("load_t2_d_rsp", d_rsp_valid, 1'b1);
        `CHK("load_t2_data", d_rsp_data, 32'hDEADBEEF);
        `CHK("load_t2_if_rsp", if_rsp_valid, 1'b0);
        @(negedge clk);
        `CHK("load_t3_idle", busy, 1'b0);

        // Store with three stall cycles
        mem_delay = 3;
        d_op(32'h3000, 1'b1, 32'h1234_5678, 4'b0011, 1'b1);
        @(negedge clk);
        `CHK("store_we", mem_req_we, 1'b1);
        `CHK("store_be", mem_req_be, 4'b0011);
        `CHK("store_wdata", mem_req_wdata, 32'h1234_5678);
        wait_idle();

        // Fetch
        mem_delay = 0;
        if_op(32'h400);
        wait_idle();

        // Starvation: both requesters held valid
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) push_if(32'h500);
            else push_d(32'h6000, 1'b0, 32'h0, 4'hF, 1'b1);
        end
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = 32'h500;
        d_req_valid = 1'b1; d_req_addr = 32'h6000; d_req_we = 1'b0; d_req_wdata = '0; d_req_be = 4'hF;
        g = 0;
        n = 0;
        while (g < 10 && n < 200) begin
            @(negedge clk);
            n++;
            if (if_req_ready || d_req_ready) g++;
        end
        if (g < 10) flag("starve_grant_timeout");
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        d_req_valid = 1'b0;
        wait_idle();

        // Backpressure: ten stall cycles while IF waits
        mem_delay = 10;
        push_d(32'h7000, 1'b1, 32'hCAFE_F00D, 4'b1100, 1'b1);
        push_if(32'h800);
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = 32'h800;
        d_req_valid = 1'b1; d_req_addr = 32'h7000; d_req_we = 1'b1; d_req_wdata = 32'hCAFE_F00D; d_req_be = 4'b1100;
        wait_ready(1'b1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        wait_ready(1'b0);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        wait_idle();
        mem_delay = 0;

        // Stray response in IDLE
        @(negedge clk);
        `CHK("stray_pre_proto_err", proto_err, 1'b0);
        @(posedge clk); #1;
        stray_req = 1'b1;
        @(posedge clk); #1;
        stray_req = 1'b0;
        @(negedge clk);
        `CHK("stray_no_rsp", {if_rsp_valid, d_rsp_valid}, 2'b00);
        @(negedge clk);
        `CHK("stray_proto_err", proto_err, 1'b1);
        d_op(32'h2000, 1'b0, 32'h0, 4'hF, 1'b1);
        wait_idle();
        `CHK("stray_proto_err_sticky", proto_err, 1'b1);

        // Reset asserted while waiting in RSP
        hold_rsp = 1'b1;
        d_op(32'h9000, 1'b0, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        `CHK("midrsp_busy", busy, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        `CHK("midrsp_rst_busy", busy, 1'b0);
        `CHK("midrsp_rst_ready", {if_req_ready, d_req_ready}, 2'b00);
        `CHK("midrsp_rst_mem_valid", mem_req_valid, 1'b0);
        `CHK("midrsp_rst_addr", mem_req_addr, 32'h0);
        `CHK("midrsp_rst_rsp", {if_rsp_valid, d_rsp_valid}, 2'b00);
        `CHK("midrsp_rst_proto_err", proto_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        hold_rsp = 1'b0;
        rst_n = 1'b1;
        push_if(32'h100);
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = 32'h100;
        @(negedge clk);
        `CHK("post_rst_if_grant", if_req_ready, 1'b1);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        wait_idle();

        // Response together with mem_req_ready in REQ is ignored
        push_d(32'hA000, 1'b0, 32'h0, 4'hF, 1'b1);
        @(posedge clk); #1;
        d_req_valid = 1'b1; d_req_addr = 32'hA000; d_req_we = 1'b0; d_req_wdata = '0; d_req_be = 4'hF;
        stray_req = 1'b1;
        wait_ready(1'b1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        stray_req = 1'b0;
        @(negedge clk);
        `CHK("req_stray_no_rsp", d_rsp_valid, 1'b0);
        @(negedge clk);
        `CHK("req_stray_proto_err", proto_err, 1'b1);
        `CHK("req_stray_real_rsp", d_rsp_valid, 1'b1);
        wait_idle();

        repeat (2) @(negedge clk);
        `CHK("left_grants", exp_grant.size(), 0);
        `CHK("left_mem_reqs", exp_mreq.size(), 0);
        `CHK("left_rsps", exp_rsp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/lx32_mem_arbiter.md
# lx32_mem_arbiter

Shares the single LX32 memory port between the instruction-fetch requester (IF) and the load/store requester (D). It sits between the core (fetch stage and LSU) and the memory bus. It grants one requester at a time and keeps exactly one transaction outstanding. D has fixed priority, and a starvation counter bounds how long IF can wait. Each response is routed back to the requester that issued the request.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. `DATA_W/8` byte enables.
- `STARVE_LIMIT`, default 4: number of consecutive lost arbitrations after which IF wins. Legal range is 1..15.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req_valid` in 1, `if_req_ready` out 1, `if_req_addr` in ADDR_W: fetch request channel.
- `if_rsp_valid` out 1, `if_rsp_data` out DATA_W: fetch response.
- `d_req_valid` in 1, `d_req_ready` out 1, `d_req_addr` in ADDR_W, `d_req_we` in 1, `d_req_wdata` in DATA_W, `d_req_be` in DATA_W/8: load/store request channel.
- `d_rsp_valid` out 1, `d_rsp_data` out DATA_W: load data, or store acknowledge.
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_req_addr` out ADDR_W, `mem_req_we` out 1, `mem_req_wdata` out DATA_W, `mem_req_be` out DATA_W/8: memory request channel.
- `mem_rsp_valid` in 1, `mem_rsp_data` in DATA_W: memory response. Always exactly one response per accepted request.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `owner` out 1: owner of the current transaction, as `owner_e`.
- `proto_err` out 1: sticky flag. Set when `mem_rsp_valid` arrives outside RSP. Cleared only by reset.

## Operation
- FSM states are IDLE, REQ and RSP.
- **IDLE, arbitration:**
  - If only one requester is valid, it wins.
  - If both are valid, D wins unless `starve_cnt == STARVE_LIMIT`, in which case IF wins.
  - The winner's `*_req_ready` is asserted combinationally in the same cycle. The loser's ready stays 0.
  - On handshake, the request fields and `owner` are captured into registers, and the FSM moves to REQ.
  - An IF request carries `we=0` and `be` all-ones. `wdata` is don't-care but is driven as 0.
- **Starvation counter:** `starve_cnt` (4 bits, saturating at `STARVE_LIMIT`) is updated only on IDLE grants.
  - It increments when IF is valid but D wins.
  - It clears when IF wins.
  - It holds otherwise.
- **REQ:** `mem_req_valid=1` with the registered fields, which stay stable until `mem_req_ready`. On the handshake the FSM moves to RSP.
- **RSP:** wait for `mem_rsp_valid`.
  - In that cycle, `<owner>_rsp_valid=1` and `<owner>_rsp_data=mem_rsp_data`, passed through combinationally.
  - The FSM then returns to IDLE.
  - The non-owner's `rsp_valid` stays 0.
- **Response data outputs:** `if_rsp_data` and `d_rsp_data` are 0 whenever the corresponding `rsp_valid` is 0.
- **Stores:** still require a memory response. The response is routed to D as an acknowledge. `d_rsp_data` is passed through and is don't-care for the LSU.
- **Stray response:** a `mem_rsp_valid` arriving in IDLE or REQ sets `proto_err` and is otherwise ignored. No `rsp_valid` is pulsed.
- **No request/ready dependency:** requesters may hold valid across busy periods. No ready is given outside IDLE.

## Timing
- **Reset values:**
  - State is IDLE, `starve_cnt=0`, `owner=OWN_IF`, `proto_err=0`, and all request registers are 0.
  - All outputs read 0: `*_ready`, `*_valid`, data, `busy`.
- **Latency:** request accepted in cycle T; `mem_req_valid` in T+1; the earliest response is in T+2 (ready in T+1, response the following cycle). The earliest possible re-grant is T+3.
- **Throughput:** at most one transaction per 3 cycles.
- **Simultaneous `mem_req_ready` and `mem_rsp_valid` in REQ:** the response is ignored and `proto_err` is set.
- **Reset asserted mid-transaction:** the transaction is dropped immediately, with no response to the requester. The memory side must also be reset.
- **Requester drops valid in IDLE:** no grant, no counter change.

## Structure
- Package `lx32_mem_pkg` holds:
  - `owner_e` (OWN_IF=1'b0, OWN_D=1'b1).
  - `arb_state_e` (IDLE, REQ, RSP as 2-bit encoding).
  - The default `STARVE_LIMIT` localparam.
- The block is a single module with no sub-module. Arbitration, FSM and response routing fit in one file of roughly 150–200 lines.

## Test plan
- **Reset:** `rst_n=0` mid-RSP → all outputs 0, `busy=0`. After release, an IF request to 0x100 is granted in the first cycle.
- **Single load:** D load from 0x2000 with `mem_req_ready=1` immediately and response 0xDEADBEEF one cycle later → `d_rsp_valid` pulses once with 0xDEADBEEF at T+2, and `if_rsp_valid` stays 0.
- **Store:** D store with wdata 0x12345678 and be=4'b0011 → the mem bus shows `we=1`, be=0011, data unchanged while ready is held low for 3 cycles. The ack pulses `d_rsp_valid`.
- **Starvation, STARVE_LIMIT=4:** IF and D both valid continuously → grant sequence D,D,D,D,IF,D,D,D,D,IF.
- **Stray response:** `mem_rsp_valid` pulsed in IDLE → `proto_err=1` sticky, no `rsp_valid` on either port, and later transactions complete normally.
- **Backpressure:** `mem_req_ready` held low for 10 cycles → `mem_req_addr`, `we`, `wdata` and `be` stay stable, and neither `req_ready` is asserted while busy.
